// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: bring-up sequencer that programs the PLL register block over a
// simple strobe bus (divider, VCO gain, loop filter), optionally reads each
// register back, writes the enable bit and waits for a stable pll_lock.
//
// Build option: define PLL_CFG_READBACK_EN to include the RD/CMP readback and
// retry flow. Without it every register is written once, ren stays 0 and
// rdata / MAX_RETRY are not used.
//
// Bus protocol: a transfer is one cycle with exactly one of wen/ren high;
// addr (and wdata for writes) are valid only in that cycle and are 0 in every
// other cycle. There is no back-pressure: the register block always accepts a
// write in its strobe cycle and returns read data in the cycle after ren.
module pll_cfg_seq #(
   parameter int MAX_RETRY    = 2,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int LOCK_STABLE  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] cfg_div,
   input  logic [3:0] cfg_vco_gain,
   input  logic [1:0] cfg_lpf_rp,
   input  logic [1:0] cfg_lpf_cp,
   input  logic [1:0] cfg_lpf_c2,
   input  logic       pll_lock,
   output logic [7:0] addr,
   output logic [7:0] wdata,
   output logic       wen,
   output logic       ren,
   input  logic [7:0] rdata,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   output logic [1:0] err_addr
);

`ifdef PLL_CFG_READBACK_EN
   typedef enum logic [3:0] {
      S_IDLE, S_WR, S_RD, S_CMP, S_EN, S_WAIT_LOCK, S_DIS, S_DONE, S_ERR
   } state_t;
`else
   typedef enum logic [3:0] {
      S_IDLE, S_WR, S_EN, S_WAIT_LOCK, S_DIS, S_DONE, S_ERR
   } state_t;
`endif

   // Saturating counter widths; guarded so a parameter of 0 still gives 1 bit.
   localparam int TMO_W  = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
   localparam int LOCK_W = (LOCK_STABLE < 1) ? 1 : $clog2(LOCK_STABLE + 1);
   localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_STABLE);

   localparam logic [1:0] EC_NONE     = 2'b00;
   localparam logic [1:0] EC_MISMATCH = 2'b01;
   localparam logic [1:0] EC_TIMEOUT  = 2'b10;
   localparam logic [1:0] EC_ABORT    = 2'b11;

   state_t            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
   logic [LOCK_W-1:0] lock_q, lock_d, lock_inc;
   logic              en_written_q, en_written_d;

   // Shadow copies of the configuration, captured when start is accepted.
   logic [7:0]        sh_div_q, sh_div_d;
   logic [3:0]        sh_vco_q, sh_vco_d;
   logic [1:0]        sh_rp_q, sh_rp_d;
   logic [1:0]        sh_cp_q, sh_cp_d;
   logic [1:0]        sh_c2_q, sh_c2_d;

   logic [7:0]        addr_d, wdata_d;
   logic              wen_d, busy_d, done_d, err_d;
   logic [1:0]        err_code_d, err_addr_d;

`ifdef PLL_CFG_READBACK_EN
   localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);
   logic [RTY_W-1:0]  retry_q, retry_d;
   logic              ren_d;
`else
   logic              unused_inputs;
   assign unused_inputs = ^{rdata, 32'(MAX_RETRY)};
   assign ren = 1'b0;
`endif

   // Byte that register i must hold for the given configuration.
   function automatic logic [7:0] exp_byte(input logic [1:0] i,
                                           input logic [7:0] div,
                                           input logic [3:0] vco,
                                           input logic [1:0] rp,
                                           input logic [1:0] cp,
                                           input logic [1:0] c2);
      logic [7:0] b;
      case (i)
         2'd0:    b = div;
         2'd1:    b = {4'b0000, vco};
         default: b = {2'b00, c2, cp, rp};
      endcase
      return b;
   endfunction

   function automatic logic is_busy(input state_t s);
      return !(s == S_IDLE || s == S_DONE || s == S_ERR);
   endfunction

   // Next-state, counter, flag and next-output logic.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      en_written_d = en_written_q;
      tmo_d        = '0;
      lock_d       = '0;
      sh_div_d     = sh_div_q;
      sh_vco_d     = sh_vco_q;
      sh_rp_d      = sh_rp_q;
      sh_cp_d      = sh_cp_q;
      sh_c2_d      = sh_c2_q;
      done_d       = done;
      err_d        = err;
      err_code_d   = err_code;
      err_addr_d   = err_addr;
`ifdef PLL_CFG_READBACK_EN
      retry_d      = retry_q;
`endif
      tmo_inc  = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
      lock_inc = (lock_q == LOCK_MAX) ? lock_q : lock_q + LOCK_W'(1);

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               sh_div_d     = cfg_div;
               sh_vco_d     = cfg_vco_gain;
               sh_rp_d      = cfg_lpf_rp;
               sh_cp_d      = cfg_lpf_cp;
               sh_c2_d      = cfg_lpf_c2;
               done_d       = 1'b0;
               err_d        = 1'b0;
               err_code_d   = EC_NONE;
               err_addr_d   = 2'd0;
               idx_d        = 2'd0;
               en_written_d = 1'b0;
`ifdef PLL_CFG_READBACK_EN
               retry_d      = '0;
`endif
               state_d      = S_WR;
            end
         end
         S_WR: begin
`ifdef PLL_CFG_READBACK_EN
            state_d = S_RD;
`else
            if (idx_q == 2'd2) begin
               state_d = S_EN;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = S_WR;
            end
`endif
         end
`ifdef PLL_CFG_READBACK_EN
         S_RD: begin
            state_d = S_CMP;
         end
         S_CMP: begin
            if (rdata == exp_byte(idx_q, sh_div_q, sh_vco_q, sh_rp_q, sh_cp_q, sh_c2_q)) begin
               if (idx_q == 2'd2) begin
                  state_d = S_EN;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  retry_d = '0;
                  state_d = S_WR;
               end
            end else if (retry_q < RTY_MAX) begin
               retry_d = retry_q + RTY_W'(1);
               state_d = S_WR;
            end else begin
               // Enable was never written, so the register block is left as is.
               err_code_d = EC_MISMATCH;
               err_addr_d = idx_q;
               state_d    = S_ERR;
            end
         end
`endif
         S_EN: begin
            state_d = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            tmo_d  = tmo_inc;
            lock_d = pll_lock ? lock_inc : '0;
            // Lock is checked first so it wins a same-cycle tie with timeout.
            if (lock_d == LOCK_MAX) begin
               state_d = S_DONE;
            end else if (tmo_d == TMO_MAX) begin
               err_code_d = EC_TIMEOUT;
               err_addr_d = 2'd3;
               state_d    = S_DIS;
            end
         end
         S_DIS: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort beats every other transition; the strobe already on the bus
      // this cycle is registered and completes regardless.
      if (abort && is_busy(state_q)) begin
         state_d    = en_written_q ? S_DIS : S_ERR;
         err_code_d = EC_ABORT;
         err_addr_d = 2'd3;
      end

      // en_written tracks "PLL enable is set and not yet undone", so a second
      // abort while the disable write is on the bus goes straight to ERR.
      if (state_d == S_EN) en_written_d = 1'b1;
      if (state_d == S_DIS) en_written_d = 1'b0;
      if (state_d == S_DONE) done_d = 1'b1;
      if (state_d == S_ERR) err_d = 1'b1;

      // Bus outputs are derived from the next state so they appear registered
      // in the same cycle the FSM occupies the matching state.
      wen_d   = 1'b0;
      addr_d  = 8'h00;
      wdata_d = 8'h00;
`ifdef PLL_CFG_READBACK_EN
      ren_d   = 1'b0;
`endif
      case (state_d)
         S_WR: begin
            wen_d   = 1'b1;
            addr_d  = {6'b000000, idx_d};
            wdata_d = exp_byte(idx_d, sh_div_d, sh_vco_d, sh_rp_d, sh_cp_d, sh_c2_d);
         end
`ifdef PLL_CFG_READBACK_EN
         S_RD: begin
            ren_d  = 1'b1;
            addr_d = {6'b000000, idx_d};
         end
`endif
         S_EN: begin
            wen_d   = 1'b1;
            addr_d  = 8'h03;
            wdata_d = 8'h01;
         end
         S_DIS: begin
            wen_d   = 1'b1;
            addr_d  = 8'h03;
            wdata_d = 8'h00;
         end
         default: begin
         end
      endcase
      busy_d = is_busy(state_d);
   end

   // State, counters, shadow registers and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= 2'd0;
         tmo_q        <= '0;
         lock_q       <= '0;
         en_written_q <= 1'b0;
         sh_div_q     <= 8'h00;
         sh_vco_q     <= 4'h0;
         sh_rp_q      <= 2'd0;
         sh_cp_q      <= 2'd0;
         sh_c2_q      <= 2'd0;
         addr         <= 8'h00;
         wdata        <= 8'h00;
         wen          <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= 2'b00;
         err_addr     <= 2'd0;
`ifdef PLL_CFG_READBACK_EN
         retry_q      <= '0;
         ren          <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         tmo_q        <= tmo_d;
         lock_q       <= lock_d;
         en_written_q <= en_written_d;
         sh_div_q     <= sh_div_d;
         sh_vco_q     <= sh_vco_d;
         sh_rp_q      <= sh_rp_d;
         sh_cp_q      <= sh_cp_d;
         sh_c2_q      <= sh_c2_d;
         addr         <= addr_d;
         wdata        <= wdata_d;
         wen          <= wen_d;
         busy         <= busy_d;
         done         <= done_d;
         err          <= err_d;
         err_code     <= err_code_d;
         err_addr     <= err_addr_d;
`ifdef PLL_CFG_READBACK_EN
         retry_q      <= retry_d;
         ren          <= ren_d;
`endif
      end
   end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb_pll_cfg_seq: testbench for pll_cfg_seq. A register-block model answers
// the bus; every expected bus transfer is queued before the sequence starts
// and checked against what the DUT drives.
module tb_pll_cfg_seq;
   localparam int MAX_RETRY    = 2;
   localparam int LOCK_TIMEOUT = 1024;
   localparam int LOCK_STABLE  = 8;
`ifdef PLL_CFG_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif
   // Cycles from the start cycle to entering WAIT_LOCK-1 (the EN cycle).
   localparam int SEQ_CYC = (RB != 0) ? 10 : 4;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] cfg_div = 8'h00;
   logic [3:0] cfg_vco_gain = 4'h0;
   logic [1:0] cfg_lpf_rp = 2'd0;
   logic [1:0] cfg_lpf_cp = 2'd0;
   logic [1:0] cfg_lpf_c2 = 2'd0;
   logic       pll_lock = 1'b0;
   logic [7:0] addr, wdata, rdata;
   logic       wen, ren, busy, done, err;
   logic [1:0] err_code, err_addr;

   always #5 clk = ~clk;

   pll_cfg_seq #(
      .MAX_RETRY(MAX_RETRY), .LOCK_TIMEOUT(LOCK_TIMEOUT), .LOCK_STABLE(LOCK_STABLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_div(cfg_div), .cfg_vco_gain(cfg_vco_gain), .cfg_lpf_rp(cfg_lpf_rp),
      .cfg_lpf_cp(cfg_lpf_cp), .cfg_lpf_c2(cfg_lpf_c2), .pll_lock(pll_lock),
      .addr(addr), .wdata(wdata), .wen(wen), .ren(ren), .rdata(rdata),
      .busy(busy), .done(done), .err(err), .err_code(err_code), .err_addr(err_addr)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------- register block model ----------------
   // Reads of addr 1 return 0x00 for the first bad_rd1_limit reads after start.
   logic [7:0] regs [0:3];
   int         bad_rd1_limit = 0;
   int         rd1_seen;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
         rdata    <= 8'h00;
         rd1_seen <= 0;
      end else begin
         if (start && !busy) rd1_seen <= 0;
         if (wen) regs[addr[1:0]] <= wdata;
         if (ren) begin
            if (addr == 8'd1 && rd1_seen < bad_rd1_limit) begin
               rdata    <= 8'h00;
               rd1_seen <= rd1_seen + 1;
            end else begin
               rdata <= regs[addr[1:0]];
            end
         end else begin
            rdata <= 8'h00;
         end
      end
   end

   // ---------------- scoreboard ----------------
   // Entry: {wen, ren, addr, wdata (0 for reads)}.
   logic [17:0] exp_q[$];

   always @(negedge clk) begin
      logic [17:0] obs;
      logic [17:0] e;
      if (rst_n) begin
         vectors++;
         if (wen || ren) begin
            obs = {wen, ren, addr, (wen ? wdata : 8'h00)};
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL bus_txn: got wen=%0b ren=%0b addr=%0d wdata=%02h, expected no transfer",
                        wen, ren, addr, wdata);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  miscompares++;
                  $display("FAIL bus_txn: got wen=%0b ren=%0b addr=%0d wdata=%02h, expected wen=%0b ren=%0b addr=%0d wdata=%02h",
                           obs[17], obs[16], obs[15:8], obs[7:0], e[17], e[16], e[15:8], e[7:0]);
               end
            end
         end else if (addr !== 8'h00 || wdata !== 8'h00) begin
            miscompares++;
            $display("FAIL bus_idle: got addr=%02h wdata=%02h, expected 00/00", addr, wdata);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_txn(input logic w, input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({w, ~w, a, (w ? d : 8'h00)});
   endtask

   task automatic push_reg(input logic [7:0] a, input logic [7:0] d);
      push_txn(1'b1, a, d);
      if (RB != 0) push_txn(1'b0, a, 8'h00);
   endtask

   task automatic push_full(input logic [7:0] div, input logic [3:0] vco,
                            input logic [1:0] rp, input logic [1:0] cp, input logic [1:0] c2);
      push_reg(8'd0, div);
      push_reg(8'd1, {4'b0000, vco});
      push_reg(8'd2, {2'b00, c2, cp, rp});
      push_txn(1'b1, 8'd3, 8'h01);
   endtask

   // Pulses start for one cycle, then scrambles cfg_* to show they are latched.
   // Returns at the negedge of the first cycle after the start cycle.
   task automatic start_seq(input logic [7:0] div, input logic [3:0] vco,
                            input logic [1:0] rp, input logic [1:0] cp, input logic [1:0] c2);
      @(negedge clk);
      cfg_div = div; cfg_vco_gain = vco; cfg_lpf_rp = rp; cfg_lpf_cp = cp; cfg_lpf_c2 = c2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg_div      = 8'($urandom_range(0, 255));
      cfg_vco_gain = 4'($urandom_range(0, 15));
      cfg_lpf_rp   = 2'($urandom_range(0, 3));
      cfg_lpf_cp   = 2'($urandom_range(0, 3));
      cfg_lpf_c2   = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_end(input int budget, output int n);
      n = 1;
      while (!(done || err) && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int budget, output logic found, output int n);
      n = 0;
      while (!(wen === w && ren === ~w && addr === a && (!w || wdata === d)) && n < budget) begin
         @(negedge clk);
         n++;
      end
      found = (n < budget);
   endtask

   task automatic flush_queue(input string name);
      repeat (4) @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_queue: %0d expected transfers never seen, expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [24:0] obs;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      obs = {addr, wdata, wen, ren, busy, done, err, err_code, err_addr};
      vectors++;
      if (obs !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %07h, expected 0000000", obs);
      end
   endtask

   task automatic test_nominal();
      int n;
      pll_lock = 1'b1;
      push_full(8'h20, 4'h5, 2'd1, 2'd2, 2'd3);
      start_seq(8'h20, 4'h5, 2'd1, 2'd2, 2'd3);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++; $display("FAIL nominal_busy: got %b, expected 1", busy);
      end
      wait_end(200, n);
      vectors++;
      if (n != SEQ_CYC + LOCK_STABLE + 1) begin
         miscompares++; $display("FAIL nominal_latency: got %0d cycles, expected %0d", n, SEQ_CYC + LOCK_STABLE + 1);
      end
      vectors++;
      if ({done, err, busy, err_code, err_addr} !== 7'b100_00_00) begin
         miscompares++;
         $display("FAIL nominal_flags: got done=%b err=%b busy=%b code=%b addr=%0d, expected 1 0 0 00 0",
                  done, err, busy, err_code, err_addr);
      end
      flush_queue("nominal");
   endtask

   task automatic test_back_to_back();
      int n;
      logic [7:0] div;
      logic [3:0] vco;
      logic [1:0] rp, cp, c2;
      for (int k = 0; k < 2; k++) begin
         div = 8'($urandom_range(0, 255)); vco = 4'($urandom_range(0, 15));
         rp = 2'($urandom_range(0, 3)); cp = 2'($urandom_range(0, 3)); c2 = 2'($urandom_range(0, 3));
         push_full(div, vco, rp, cp, c2);
         start_seq(div, vco, rp, cp, c2);
         vectors++;
         if (done !== 1'b0) begin
            miscompares++; $display("FAIL b2b_done_clear: got %b, expected 0", done);
         end
         wait_end(200, n);
         vectors++;
         if (done !== 1'b1 || err !== 1'b0) begin
            miscompares++; $display("FAIL b2b_done: got done=%b err=%b, expected 1 0", done, err);
         end
         while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
      end
      flush_queue("b2b");
   endtask

   task automatic test_overlap();
      int n;
      pll_lock = 1'b1;
      push_full(8'hA7, 4'hC, 2'd3, 2'd0, 2'd1);
      start_seq(8'hA7, 4'hC, 2'd3, 2'd0, 2'd1);
      @(negedge clk);
      cfg_div = 8'h11; cfg_vco_gain = 4'h2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 3;
      while (!(done || err) && n < 200) begin @(negedge clk); n++; end
      vectors++;
      if (n != SEQ_CYC + LOCK_STABLE + 1 || done !== 1'b1) begin
         miscompares++;
         $display("FAIL overlap_done: got done=%b after %0d cycles, expected 1 after %0d", done, n, SEQ_CYC + LOCK_STABLE + 1);
      end
      flush_queue("overlap");
   endtask

`ifdef PLL_CFG_READBACK_EN
   task automatic test_retry_recover();
      int n;
      pll_lock = 1'b1;
      bad_rd1_limit = MAX_RETRY;
      push_reg(8'd0, 8'h3C);
      for (int k = 0; k <= MAX_RETRY; k++) push_reg(8'd1, 8'h09);
      push_reg(8'd2, 8'h1B);
      push_txn(1'b1, 8'd3, 8'h01);
      start_seq(8'h3C, 4'h9, 2'd3, 2'd2, 2'd1);
      wait_end(300, n);
      vectors++;
      if (n != SEQ_CYC + 3 * MAX_RETRY + LOCK_STABLE + 1 || done !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL retry_recover: got done=%b err=%b after %0d cycles, expected 1 0 after %0d",
                  done, err, n, SEQ_CYC + 3 * MAX_RETRY + LOCK_STABLE + 1);
      end
      bad_rd1_limit = 0;
      flush_queue("retry_recover");
   endtask

   task automatic test_mismatch();
      int n;
      pll_lock = 1'b1;
      bad_rd1_limit = MAX_RETRY + 1;
      push_reg(8'd0, 8'h20);
      for (int k = 0; k <= MAX_RETRY; k++) push_reg(8'd1, 8'h05);
      start_seq(8'h20, 4'h5, 2'd1, 2'd2, 2'd3);
      wait_end(300, n);
      vectors++;
      if ({done, err, err_code, err_addr} !== 6'b01_01_01) begin
         miscompares++;
         $display("FAIL mismatch_flags: got done=%b err=%b code=%b addr=%0d, expected 0 1 01 1",
                  done, err, err_code, err_addr);
      end
      bad_rd1_limit = 0;
      flush_queue("mismatch");
   endtask
`endif

   task automatic test_timeout();
      logic found;
      int n;
      pll_lock = 1'b0;
      push_full(8'h44, 4'h3, 2'd0, 2'd1, 2'd2);
      push_txn(1'b1, 8'd3, 8'h00);
      start_seq(8'h44, 4'h3, 2'd0, 2'd1, 2'd2);
      wait_txn(1'b1, 8'd3, 8'h01, 60, found, n);
      vectors++;
      if (!found) begin miscompares++; $display("FAIL timeout_en: enable write not seen, expected within 60 cycles"); end
      wait_txn(1'b1, 8'd3, 8'h00, LOCK_TIMEOUT + 20, found, n);
      vectors++;
      if (!found || n != LOCK_TIMEOUT + 1) begin
         miscompares++;
         $display("FAIL timeout_dis: disable write after %0d cycles (found=%b), expected %0d", n, found, LOCK_TIMEOUT + 1);
      end
      @(negedge clk);
      vectors++;
      if ({done, err, err_code, err_addr} !== 6'b01_10_11) begin
         miscompares++;
         $display("FAIL timeout_flags: got done=%b err=%b code=%b addr=%0d, expected 0 1 10 3",
                  done, err, err_code, err_addr);
      end
      flush_queue("timeout");
   endtask

   task automatic test_glitch();
      logic found;
      int n;
      pll_lock = 1'b0;
      push_full(8'h81, 4'hF, 2'd2, 2'd2, 2'd0);
      start_seq(8'h81, 4'hF, 2'd2, 2'd2, 2'd0);
      wait_txn(1'b1, 8'd3, 8'h01, 60, found, n);
      vectors++;
      if (!found) begin miscompares++; $display("FAIL glitch_en: enable write not seen, expected within 60 cycles"); end
      pll_lock = 1'b1;
      repeat (LOCK_STABLE) @(negedge clk);
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      n = LOCK_STABLE + 1;
      while (!(done || err) && n < 100) begin @(negedge clk); n++; end
      vectors++;
      if (n != 2 * LOCK_STABLE + 1 || done !== 1'b1 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL glitch_done: got done=%b err=%b %0d cycles after enable, expected 1 0 after %0d",
                  done, err, n, 2 * LOCK_STABLE + 1);
      end
      flush_queue("glitch");
   endtask

   task automatic test_abort_early();
      logic found;
      int n;
      pll_lock = 1'b1;
      push_reg(8'd0, 8'h20);
      push_reg(8'd1, 8'h05);
      start_seq(8'h20, 4'h5, 2'd1, 2'd2, 2'd3);
`ifdef PLL_CFG_READBACK_EN
      wait_txn(1'b0, 8'd1, 8'h00, 40, found, n);
      @(negedge clk);
`else
      wait_txn(1'b1, 8'd1, 8'h05, 40, found, n);
`endif
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if (!found || {done, err, busy, err_code, err_addr} !== 7'b01_0_11_11) begin
         miscompares++;
         $display("FAIL abort_early_flags: got found=%b done=%b err=%b busy=%b code=%b addr=%0d, expected 1 0 1 0 11 3",
                  found, done, err, busy, err_code, err_addr);
      end
      flush_queue("abort_early");
   endtask

   task automatic test_abort_lock();
      logic found;
      int n;
      pll_lock = 1'b0;
      push_full(8'h5A, 4'h6, 2'd1, 2'd1, 2'd1);
      push_txn(1'b1, 8'd3, 8'h00);
      start_seq(8'h5A, 4'h6, 2'd1, 2'd1, 2'd1);
      wait_txn(1'b1, 8'd3, 8'h01, 60, found, n);
      vectors++;
      if (!found) begin miscompares++; $display("FAIL abort_lock_en: enable write not seen, expected within 60 cycles"); end
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({wen, addr, wdata} !== {1'b1, 8'd3, 8'h00}) begin
         miscompares++;
         $display("FAIL abort_lock_dis: got wen=%b addr=%0d wdata=%02h, expected 1 3 00", wen, addr, wdata);
      end
      @(negedge clk);
      vectors++;
      if ({done, err, err_code, err_addr} !== 6'b01_11_11) begin
         miscompares++;
         $display("FAIL abort_lock_flags: got done=%b err=%b code=%b addr=%0d, expected 0 1 11 3",
                  done, err, err_code, err_addr);
      end
      flush_queue("abort_lock");
   endtask

   task automatic test_reset_mid();
      logic found;
      int n;
      logic [24:0] obs;
      pll_lock = 1'b1;
      push_reg(8'd0, 8'hC3);
      push_txn(1'b1, 8'd1, 8'h07);
      start_seq(8'hC3, 4'h7, 2'd0, 2'd3, 2'd2);
      wait_txn(1'b1, 8'd1, 8'h07, 40, found, n);
      #2 rst_n = 1'b0;
      #1;
      obs = {addr, wdata, wen, ren, busy, done, err, err_code, err_addr};
      vectors++;
      if (!found || obs !== 25'd0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got found=%b outputs=%07h, expected 1 0000000", found, obs);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      vectors++;
      if ({busy, done, err} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_mid_idle: got busy=%b done=%b err=%b, expected 0 0 0", busy, done, err);
      end
      flush_queue("reset_mid");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_back_to_back();
      test_overlap();
`ifdef PLL_CFG_READBACK_EN
      test_retry_recover();
      test_mismatch();
`endif
      test_timeout();
      test_glitch();
      test_abort_early();
      test_abort_lock();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
